// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder
//   WIDTH-bit unsigned adder split into STAGES ripple-carry chunks of
//   CHUNK = WIDTH/STAGES bits. One chunk is added per clock and its carry is
//   registered, so the longest path is a single CHUNK-bit ripple.
//
//   Handshake: a beat moves on a clock edge when valid && ready on that side.
//   The whole pipe advances together (adv = !out_valid || out_ready). in_ready
//   equals adv and never depends on in_valid. Bubbles travel as valid=0
//   entries and are not collapsed. A stall freezes every stage, so sum/cout
//   stay stable while out_valid && !out_ready.
//
//   Optional feature: define ADDER_SUB_EN to add a 'sub' input sampled with
//   a/b. sub=1 computes a + ~b + 1 (cin ignored), so cout=1 means no borrow.
//   The inverted b is what travels down the pipe, which keeps sub attached to
//   its own operands.
module pipelined_ripple_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CHUNK = WIDTH / STAGES;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

`ifdef ADDER_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  // Bit-serial ripple of one chunk; returns {carry_out, chunk_sum}.
  function automatic logic [CHUNK:0] ripple(input logic [CHUNK-1:0] x,
                                            input logic [CHUNK-1:0] y,
                                            input logic             ci);
    logic             c;
    logic [CHUNK-1:0] s;
    c = ci;
    s = '0;
    for (int i = 0; i < CHUNK; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, s};
  endfunction

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : stg
      // DONE = sum bits finished after this stage; PEND = operand bits still to add.
      localparam int DONE = (k + 1) * CHUNK;
      localparam int PEND = WIDTH - DONE;

      logic             v_q;
      logic             c_q;
      logic [DONE-1:0]  sum_q;
      logic             v_d;
      logic [DONE-1:0]  sum_d;
      logic [CHUNK-1:0] xa;
      logic [CHUNK-1:0] xb;
      logic             ci;
      logic [CHUNK:0]   r;

      if (k == 0) begin : src
        assign v_d   = in_valid && in_ready;
        assign xa    = a[CHUNK-1:0];
        assign xb    = b_eff[CHUNK-1:0];
        assign ci    = cin_eff;
        assign sum_d = r[CHUNK-1:0];
      end else begin : src
        assign v_d   = stg[k-1].v_q;
        assign xa    = stg[k-1].pend.pa_q[CHUNK-1:0];
        assign xb    = stg[k-1].pend.pb_q[CHUNK-1:0];
        assign ci    = stg[k-1].c_q;
        assign sum_d = {r[CHUNK-1:0], stg[k-1].sum_q};
      end

      assign r = ripple(xa, xb, ci);

      // Stage result register: valid flag, chunk carry and finished low sum bits.
      always_ff @(posedge clk) begin
        if (rst) begin
          v_q   <= 1'b0;
          c_q   <= 1'b0;
          sum_q <= '0;
        end else if (adv) begin
          v_q   <= v_d;
          c_q   <= r[CHUNK];
          sum_q <= sum_d;
        end
      end

      if (PEND > 0) begin : pend
        logic [PEND-1:0] pa_q;
        logic [PEND-1:0] pb_q;
        logic [PEND-1:0] pa_d;
        logic [PEND-1:0] pb_d;

        if (k == 0) begin : from_in
          assign pa_d = a[WIDTH-1:CHUNK];
          assign pb_d = b_eff[WIDTH-1:CHUNK];
        end else begin : from_prev
          assign pa_d = stg[k-1].pend.pa_q[PEND+CHUNK-1:CHUNK];
          assign pb_d = stg[k-1].pend.pb_q[PEND+CHUNK-1:CHUNK];
        end

        // Upper operand bits waiting for their chunk in a later stage.
        always_ff @(posedge clk) begin
          if (rst) begin
            pa_q <= '0;
            pb_q <= '0;
          end else if (adv) begin
            pa_q <= pa_d;
            pb_q <= pb_d;
          end
        end
      end
    end
  endgenerate

  assign out_valid = stg[STAGES-1].v_q;
  assign sum       = stg[STAGES-1].sum_q;
  assign cout      = stg[STAGES-1].c_q;

endmodule
